// File: rtl/multimode_ff_pkg.sv
// Shared mode and SR-conflict policy definitions for the multimode flip-flop bank.
package multimode_ff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SR = 2'b00;
  localparam mode_t MODE_JK = 2'b01;
  localparam mode_t MODE_D  = 2'b10;
  localparam mode_t MODE_T  = 2'b11;

  localparam int POL_HOLD = 0;
  localparam int POL_SET  = 1;
  localparam int POL_RST  = 2;

endpackage

// File: rtl/ff_cell.sv
// One bit of the bank: mode-selected next-state logic, the q register and an SR-conflict pulse.
module ff_cell
  import multimode_ff_pkg::*;
#(
  parameter int SR_POLICY = POL_HOLD
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  mode_t mode,
  input  logic  s,
  input  logic  r,
  output logic  q,
  output logic  conflict
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d      = q_q;
    conflict = 1'b0;
    if (en) begin
      case (mode)
        MODE_SR: begin
          case ({s, r})
            2'b01: q_d = 1'b0;
            2'b10: q_d = 1'b1;
            2'b11: begin
              // S=R=1 resolves to a defined value chosen at elaboration time
              conflict = 1'b1;
              if (SR_POLICY == POL_SET) begin
                q_d = 1'b1;
              end else if (SR_POLICY == POL_RST) begin
                q_d = 1'b0;
              end
            end
            default: q_d = q_q;
          endcase
        end
        MODE_JK: begin
          case ({s, r})
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
          endcase
        end
        MODE_D:  q_d = s;
        default: q_d = s ? ~q_q : q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/multimode_ff_bank.sv
// WIDTH-bit bank of SR/JK/D/T flip-flops with sticky per-bit SR-conflict flags
// and a saturating count of conflict cycles.
module multimode_ff_bank
  import multimode_ff_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CNT_W     = 4,
  parameter int SR_POLICY = POL_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] err_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] conflict_vec;
  logic             any_conflict;
  logic [WIDTH-1:0] err_q;
  logic [WIDTH-1:0] err_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_base;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .SR_POLICY (SR_POLICY)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode_t'(mode)),
      .s        (s[i]),
      .r        (r[i]),
      .q        (q[i]),
      .conflict (conflict_vec[i])
    );
  end

  assign any_conflict = |conflict_vec;

  // clr_err wipes history first, so a same-edge conflict becomes the only recorded event
  always_comb begin
    err_d    = clr_err ? conflict_vec : (err_q | conflict_vec);
    cnt_base = clr_err ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (any_conflict && (cnt_base != CNT_MAX)) begin
      cnt_d = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_bar        = ~q;
  assign err_sticky   = err_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: doc/multimode_ff_bank.md
Name: multimode_ff_bank

Overview:
- Parametrised bank of WIDTH clocked flip-flops. A runtime mode input selects the behaviour of every bit: SR, JK, D or T.
- Replaces single-bit SR storage elements with a deterministic, configurable register.
- The S=R=1 conflict never produces X. A parameter policy resolves it, and the bank flags it through sticky per-bit error bits and a saturating event counter.
- Sits wherever the design needs small control/status latches with selectable update semantics.

Parameters:
- WIDTH, 4, number of flip-flop bits (1..32).
- CNT_W, 4, width of the conflict event counter (1..16).
- SR_POLICY, 0, SR-mode S=R=1 resolution: 0 = hold, 1 = set-dominant, 2 = reset-dominant.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset; sampled on rising clk.
- en  input  1  update enable; 0 = hold everything.
- mode  input  2  00 SR, 01 JK, 10 D, 11 T.
- s  input  WIDTH  S (SR) / J (JK) / D (D) / T (T) per bit.
- r  input  WIDTH  R (SR) / K (JK); ignored in D and T modes.
- clr_err  input  1  clears err_sticky and conflict_cnt.
- q  output  WIDTH  registered state.
- q_bar  output  WIDTH  registered complement; always equals ~q, never X.
- err_sticky  output  WIDTH  per-bit sticky SR-conflict flag.
- conflict_cnt  output  CNT_W  count of cycles with at least one SR conflict, saturating.

Behaviour:
- All outputs are registered and update on the rising clk edge. Latency is 1 cycle from input to q.
- Reset:
  - rst=1 has the highest priority: q=0, q_bar=all ones, err_sticky=0, conflict_cnt=0.
  - rst overrides en, mode and clr_err in the same cycle.
  - Reset mid-operation discards any pending toggle or conflict.
- en=0: q, q_bar, err_sticky and conflict_cnt hold. No conflict detection. clr_err is still honoured.
- en=1, per-bit next state (i = bit index):
  - SR: 00 hold; 01 → 0; 10 → 1; 11 → SR_POLICY (hold / 1 / 0).
  - JK: 00 hold; 01 → 0; 10 → 1; 11 → toggle. Not a conflict.
  - D: q[i] ← s[i].
  - T: s[i]=1 toggles, s[i]=0 holds.
- The mode value sampled at an edge applies to that edge only. Switching modes needs no drain cycle and carries no hidden state.
- Conflict event:
  - Definition: en=1, mode=SR, s[i]=r[i]=1.
  - Each conflicting bit sets err_sticky[i]=1.
  - conflict_cnt increments by exactly 1 per cycle with ≥1 conflicting bit, regardless of how many bits conflict.
  - conflict_cnt saturates at 2^CNT_W−1; it does not wrap.
- clr_err=1 (no rst):
  - err_sticky and conflict_cnt are cleared at that edge.
  - If a conflict occurs on the same edge, the new event wins: err_sticky = the conflicting bits of that cycle, conflict_cnt = 1.
- Invariant: q_bar == ~q at every cycle after the first reset.
- Before the first reset, outputs are undefined. The bench must assert rst at start.

Decomposition:
- Shared package, multimode_ff_pkg:
  - Mode constants MODE_SR=2'b00, MODE_JK=2'b01, MODE_D=2'b10, MODE_T=2'b11.
  - Policy constants POL_HOLD=0, POL_SET=1, POL_RST=2.
  - A 2-bit mode typedef.
- Sub-module ff_cell: one bit of next-state logic plus the q register. Outputs q and a conflict pulse. Instantiated WIDTH times via generate.
- The top level owns the OR-reduction of conflict pulses, err_sticky, conflict_cnt, clr_err/rst arbitration and q_bar generation.

Test Plan (WIDTH=4, CNT_W=4 unless stated):
- Reset then SR: rst=1 one edge → q=0000, q_bar=1111, cnt=0. Then en=1, mode=SR, s=0101, r=1010 → q=0101, q_bar=1010, next edge s=r=0000 → q holds 0101.
- SR conflict policy: SR_POLICY=0/1/2, q=0101, s=1100, r=1100 → q=0101 / 1101 / 0001 respectively; err_sticky=1100, cnt=1; q_bar=~q, no X.
- JK and T toggle: mode=JK, q=0011, s=r=1111 → q=1100, err_sticky unchanged, cnt unchanged. mode=T, s=1010 → q=0110.
- Counter saturation and clear:
  - 20 consecutive SR conflict cycles on bit0 → cnt reaches 15 and stays 15.
  - clr_err alone → cnt=0, err=0000.
  - clr_err with a simultaneous conflict on bit3 → err=1000, cnt=1.
- Enable and reset priority:
  - en=0 with mode=D, s=1111 → q unchanged, no counting.
  - rst=1 together with en=1, D, s=1111, clr_err=0 → q=0000, cnt=0.
- Mode switching: alternate mode D (s=1001) and T (s=1111) on consecutive edges → q=1001, then 0110, then on D with s=1001 → 1001. q_bar tracks ~q every cycle.
